// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS control unit.
// Holds the FSM state encoding, the supported opcode/funct values, and the
// encodings of every datapath control field driven by mc_ctrl.
package mc_pkg;

  // FSM states; 11 states fit in the 4-bit state register.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DCD    = 4'd1,
    S_EXE_R  = 4'd2,
    S_EXE_I  = 4'd3,
    S_MA     = 4'd4,
    S_MR     = 4'd5,
    S_MW     = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BR     = 4'd9,
    S_JMP    = 4'd10
  } state_e;

  // Opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0]).
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // ALU function codes.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_LUI = 3'd5;

  // Immediate extender modes.
  localparam logic [1:0] EXT_ZERO  = 2'd0;
  localparam logic [1:0] EXT_SIGN  = 2'd1;
  localparam logic [1:0] EXT_UPPER = 2'd2;

  // Register-file destination (A3) select.
  localparam logic [1:0] GPR_RD = 2'd0;
  localparam logic [1:0] GPR_RT = 2'd1;
  localparam logic [1:0] GPR_RA = 2'd2;

  // Register-file write-data (WD) select.
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  // Next-PC mode.
  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;

  // True when an R-type funct field names a supported instruction.
  function automatic logic funct_supported(input logic [5:0] f);
    logic ok;
    case (f)
      FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
      default:                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: instruction decoder for the multicycle control unit.
// Maps Funct (R-type) or Op (everything else) to an ALU function code and
// flags whether the instruction is part of the supported subset.
// Ports:
//   op       in  6  IR[31:26]
//   funct    in  6  IR[5:0]
//   alu_op   out 3  ALU function code for this instruction
//   instr_ok out 1  1 = supported opcode (and funct, for R-type)
module mc_alu_dec (
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       instr_ok
);
  import mc_pkg::*;

  // Opcode/funct to ALU code and legality decode.
  always_comb begin
    alu_op   = ALU_ADD;
    instr_ok = 1'b0;
    case (op)
      OP_RTYPE: begin
        instr_ok = funct_supported(funct);
        case (funct)
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      OP_ORI: begin
        alu_op   = ALU_OR;
        instr_ok = 1'b1;
      end
      OP_LUI: begin
        alu_op   = ALU_LUI;
        instr_ok = 1'b1;
      end
      OP_LW, OP_SW: begin
        alu_op   = ALU_ADD;
        instr_ok = 1'b1;
      end
      OP_BEQ: begin
        alu_op   = ALU_SUB;
        instr_ok = 1'b1;
      end
      OP_J, OP_JAL: begin
        alu_op   = ALU_ADD;
        instr_ok = 1'b1;
      end
      default: begin
        alu_op   = ALU_ADD;
        instr_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: Moore-style multicycle control unit for the MIPS datapath.
// Sequences each instruction through FETCH/DCD/EXE/MEM/WB states and drives
// every datapath write enable and mux select as a combinational decode of
// the state register plus Op, Funct and Zero.
// Ports:
//   clk     in  1  system clock, rising edge
//   rst     in  1  synchronous active-low reset
//   Op      in  6  IR[31:26]
//   Funct   in  6  IR[5:0]
//   Zero    in  1  ALU zero flag (used only in BR)
//   PCWr    out 1  PC write enable
//   IRWr    out 1  IR write enable
//   RFWr    out 1  register file write enable
//   DMWr    out 1  data memory write enable
//   BSel    out 1  ALU B source (0 RD2, 1 immediate)
//   ALUOp   out 3  ALU function code
//   EXTOp   out 2  immediate extender mode
//   GPRSel  out 2  A3 select (rd, rt, 31)
//   WDSel   out 2  WD select (ALU, DM, PC)
//   NPCOp   out 2  next-PC mode (PC+4, branch, jump)
//   Illegal out 1  one-cycle pulse in DCD for unsupported instructions
module mc_ctrl #(
  parameter int ST_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic       BSel,
  output logic [2:0] ALUOp,
  output logic [1:0] EXTOp,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic [1:0] NPCOp,
  output logic       Illegal
);
  import mc_pkg::*;

  logic [ST_W-1:0] state_r;
  state_e          cur_s;
  state_e          next_s;

  logic [2:0] dec_alu_s;
  logic       dec_ok_s;

  logic       pcwr_s;
  logic       irwr_s;
  logic       rfwr_s;
  logic       dmwr_s;
  logic       illegal_s;

  mc_alu_dec u_alu_dec (
    .op       (Op),
    .funct    (Funct),
    .alu_op   (dec_alu_s),
    .instr_ok (dec_ok_s)
  );

  assign cur_s = state_e'(state_r);

  // State register with synchronous active-low reset to FETCH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_W'(S_FETCH);
    end else begin
      state_r <= ST_W'(next_s);
    end
  end

  // Next-state and output decode; unused selects default to 0.
  always_comb begin
    next_s    = S_FETCH;
    pcwr_s    = 1'b0;
    irwr_s    = 1'b0;
    rfwr_s    = 1'b0;
    dmwr_s    = 1'b0;
    illegal_s = 1'b0;
    BSel      = 1'b0;
    ALUOp     = ALU_ADD;
    EXTOp     = EXT_ZERO;
    GPRSel    = GPR_RD;
    WDSel     = WD_ALU;
    NPCOp     = NPC_PC4;
    case (cur_s)
      S_FETCH: begin
        irwr_s = 1'b1;
        pcwr_s = 1'b1;
        NPCOp  = NPC_PC4;
        next_s = S_DCD;
      end
      S_DCD: begin
        // The decoder covers both unknown opcodes and unknown R-type functs.
        if (!dec_ok_s) begin
          illegal_s = 1'b1;
          next_s    = S_FETCH;
        end else begin
          case (Op)
            OP_RTYPE:       next_s = S_EXE_R;
            OP_ORI, OP_LUI: next_s = S_EXE_I;
            OP_LW, OP_SW:   next_s = S_MA;
            OP_BEQ:         next_s = S_BR;
            OP_J, OP_JAL:   next_s = S_JMP;
            default: begin
              illegal_s = 1'b1;
              next_s    = S_FETCH;
            end
          endcase
        end
      end
      S_EXE_R: begin
        BSel   = 1'b0;
        ALUOp  = dec_alu_s;
        next_s = S_WB_ALU;
      end
      S_EXE_I: begin
        BSel  = 1'b1;
        ALUOp = dec_alu_s;
        if (Op == OP_LUI) begin
          EXTOp = EXT_UPPER;
        end else begin
          EXTOp = EXT_ZERO;
        end
        next_s = S_WB_ALU;
      end
      S_MA: begin
        BSel  = 1'b1;
        EXTOp = EXT_SIGN;
        ALUOp = ALU_ADD;
        if (Op == OP_LW) begin
          next_s = S_MR;
        end else begin
          next_s = S_MW;
        end
      end
      S_MW: begin
        dmwr_s = 1'b1;
        next_s = S_FETCH;
      end
      S_MR: begin
        // Memory read latency cycle; nothing is written.
        next_s = S_WB_MEM;
      end
      S_WB_ALU: begin
        rfwr_s = 1'b1;
        WDSel  = WD_ALU;
        if (Op == OP_RTYPE) begin
          GPRSel = GPR_RD;
        end else begin
          GPRSel = GPR_RT;
        end
        next_s = S_FETCH;
      end
      S_WB_MEM: begin
        rfwr_s = 1'b1;
        WDSel  = WD_DM;
        GPRSel = GPR_RT;
        next_s = S_FETCH;
      end
      S_BR: begin
        ALUOp  = ALU_SUB;
        NPCOp  = NPC_BR;
        pcwr_s = Zero;
        next_s = S_FETCH;
      end
      S_JMP: begin
        pcwr_s = 1'b1;
        NPCOp  = NPC_J;
        // PC already holds PC+4 after FETCH, so it is the link value.
        if (Op == OP_JAL) begin
          rfwr_s = 1'b1;
          GPRSel = GPR_RA;
          WDSel  = WD_PC;
        end else begin
          rfwr_s = 1'b0;
        end
        next_s = S_FETCH;
      end
      default: begin
        next_s = S_FETCH;
      end
    endcase
  end

  // Write strobes are suppressed for as long as reset is held.
  assign PCWr    = rst & pcwr_s;
  assign IRWr    = rst & irwr_s;
  assign RFWr    = rst & rfwr_s;
  assign DMWr    = rst & dmwr_s;
  assign Illegal = rst & illegal_s;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed, table-driven bench for mc_ctrl. Each table row is one
// clock cycle: inputs are applied on the falling edge and all outputs are
// compared 1 time unit later against a hand-computed expected vector.
module tb_mc_ctrl;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWr, IRWr, RFWr, DMWr, BSel, Illegal;
  logic [2:0] ALUOp;
  logic [1:0] EXTOp, GPRSel, WDSel, NPCOp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.ST_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .Op      (Op),
    .Funct   (Funct),
    .Zero    (Zero),
    .PCWr    (PCWr),
    .IRWr    (IRWr),
    .RFWr    (RFWr),
    .DMWr    (DMWr),
    .BSel    (BSel),
    .ALUOp   (ALUOp),
    .EXTOp   (EXTOp),
    .GPRSel  (GPRSel),
    .WDSel   (WDSel),
    .NPCOp   (NPCOp),
    .Illegal (Illegal)
  );

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Expected output vector, packed {PCWr,IRWr,RFWr,DMWr,BSel,ALUOp,EXTOp,GPRSel,WDSel,NPCOp,Illegal}.
  function automatic logic [16:0] ex(input int pc, input int ir, input int rf, input int dm,
                                     input int b, input int alu, input int ext, input int gpr,
                                     input int wd, input int npc, input int ill);
    return {1'(pc), 1'(ir), 1'(rf), 1'(dm), 1'(b), 3'(alu), 2'(ext), 2'(gpr), 2'(wd),
            2'(npc), 1'(ill)};
  endfunction

  task automatic add(input int r, input int o, input int f, input int z, input logic [16:0] e);
    vec_t v;
    v.rst   = 1'(r);
    v.op    = 6'(o);
    v.funct = 6'(f);
    v.zero  = 1'(z);
    v.exp   = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input int r, input int o, input int f, input int z);
    @(negedge clk);
    rst   = 1'(r);
    Op    = 6'(o);
    Funct = 6'(f);
    Zero  = 1'(z);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [16:0] e);
    logic [16:0] act;
    act = {PCWr, IRWr, RFWr, DMWr, BSel, ALUOp, EXTOp, GPRSel, WDSel, NPCOp, Illegal};
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s[%0d] got=%05h exp=%05h", name, idx, act, e);
    end
  endtask

  logic [16:0] e_idle, e_fetch, e_ma, e_wb_rd, e_wb_rt;

  // Adds FETCH, DCD, EXE_R, WB_ALU rows for one R-type instruction.
  task automatic add_rtype(input int fn, input int alu);
    add(1, 'h00, fn, 0, e_fetch);
    add(1, 'h00, fn, 0, e_idle);
    add(1, 'h00, fn, 1, ex(0, 0, 0, 0, 0, alu, 0, 0, 0, 0, 0));
    add(1, 'h00, fn, 0, e_wb_rd);
  endtask

  initial begin
    rst   = 1'b0;
    Op    = 6'h00;
    Funct = 6'h21;
    Zero  = 1'b0;

    e_idle  = 17'd0;
    e_fetch = ex(1, 1, 0, 0, 0, 0, 0, 0, 0, NPC_PC4, 0);
    e_ma    = ex(0, 0, 0, 0, 1, 0, EXT_SIGN, 0, 0, 0, 0);
    e_wb_rd = ex(0, 0, 1, 0, 0, 0, 0, GPR_RD, WD_ALU, 0, 0);
    e_wb_rt = ex(0, 0, 1, 0, 0, 0, 0, GPR_RT, WD_ALU, 0, 0);

    // Reset held for 3 cycles: state sits in FETCH but every enable is forced low.
    add(0, 'h00, 'h21, 0, e_idle);
    add(0, 'h00, 'h21, 0, e_idle);
    add(0, 'h00, 'h21, 0, e_idle);
    // R-type group: addu, subu, and, or, slt.
    add_rtype('h21, 0);
    add_rtype('h23, 1);
    add_rtype('h24, 2);
    add_rtype('h25, 3);
    add_rtype('h2A, 4);
    // ori: zero-extend, ALU OR, write rt. Funct is garbage and must be ignored.
    add(1, 'h0D, 'h3F, 0, e_fetch);
    add(1, 'h0D, 'h3F, 0, e_idle);
    add(1, 'h0D, 'h3F, 0, ex(0, 0, 0, 0, 1, 3, EXT_ZERO, 0, 0, 0, 0));
    add(1, 'h0D, 'h3F, 0, e_wb_rt);
    // lui: upper-load extend, ALU LUI, write rt.
    add(1, 'h0F, 'h3F, 0, e_fetch);
    add(1, 'h0F, 'h3F, 0, e_idle);
    add(1, 'h0F, 'h3F, 0, ex(0, 0, 0, 0, 1, 5, EXT_UPPER, 0, 0, 0, 0));
    add(1, 'h0F, 'h3F, 0, e_wb_rt);
    // lw: 5 cycles, RFWr in cycle 5 with WDSel=DM and GPRSel=rt.
    add(1, 'h23, 'h3F, 0, e_fetch);
    add(1, 'h23, 'h3F, 0, e_idle);
    add(1, 'h23, 'h3F, 0, e_ma);
    add(1, 'h23, 'h3F, 1, e_idle);
    add(1, 'h23, 'h3F, 0, ex(0, 0, 1, 0, 0, 0, 0, GPR_RT, WD_DM, 0, 0));
    // sw: DMWr only in cycle 4.
    add(1, 'h2B, 'h3F, 0, e_fetch);
    add(1, 'h2B, 'h3F, 0, e_idle);
    add(1, 'h2B, 'h3F, 0, e_ma);
    add(1, 'h2B, 'h3F, 0, ex(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // beq taken (Zero=1 throughout; only BR may react to it).
    add(1, 'h04, 'h00, 1, e_fetch);
    add(1, 'h04, 'h00, 1, e_idle);
    add(1, 'h04, 'h00, 1, ex(1, 0, 0, 0, 0, 1, 0, 0, 0, NPC_BR, 0));
    // beq not taken.
    add(1, 'h04, 'h00, 0, e_fetch);
    add(1, 'h04, 'h00, 0, e_idle);
    add(1, 'h04, 'h00, 0, ex(0, 0, 0, 0, 0, 1, 0, 0, 0, NPC_BR, 0));
    // j.
    add(1, 'h02, 'h00, 0, e_fetch);
    add(1, 'h02, 'h00, 0, e_idle);
    add(1, 'h02, 'h00, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, NPC_J, 0));
    // jal: link into r31 with WD=PC.
    add(1, 'h03, 'h00, 0, e_fetch);
    add(1, 'h03, 'h00, 0, e_idle);
    add(1, 'h03, 'h00, 0, ex(1, 0, 1, 0, 0, 0, 0, GPR_RA, WD_PC, NPC_J, 0));
    // Unsupported opcode: Illegal in DCD, then straight back to FETCH.
    add(1, 'h3F, 'h00, 0, e_fetch);
    add(1, 'h3F, 'h00, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // Unsupported R-type funct.
    add(1, 'h00, 'h3F, 0, e_fetch);
    add(1, 'h00, 'h3F, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(1, 'h00, 'h21, 0, e_fetch);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(int'(tbl[i].rst), int'(tbl[i].op), int'(tbl[i].funct), int'(tbl[i].zero));
      check("vec", i, tbl[i].exp);
    end

    // Reset asserted during lw's MR: no RFWr, FETCH resumes after release.
    drive(0, 'h23, 'h00, 0); check("lw_rst_pre", 0, e_idle);
    drive(1, 'h23, 'h00, 0); check("lw_rst_fetch", 0, e_fetch);
    drive(1, 'h23, 'h00, 0); check("lw_rst_dcd", 0, e_idle);
    drive(1, 'h23, 'h00, 0); check("lw_rst_ma", 0, e_ma);
    drive(0, 'h23, 'h00, 0); check("lw_rst_mr", 0, e_idle);
    drive(0, 'h23, 'h00, 0); check("lw_rst_hold", 0, e_idle);
    drive(1, 'h23, 'h00, 0); check("lw_rst_release", 0, e_fetch);
    drive(1, 'h23, 'h00, 0); check("lw_rst_dcd2", 0, e_idle);

    // One-cycle reset pulse during sw's MA: selects stay, MW never follows.
    drive(1, 'h2B, 'h00, 0); check("sw_rst_ma", 0, e_ma);
    drive(1, 'h2B, 'h00, 0); check("sw_rst_mw", 0, ex(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    drive(1, 'h2B, 'h00, 0); check("sw_rst_fetch", 0, e_fetch);
    drive(1, 'h2B, 'h00, 0); check("sw_rst_dcd", 0, e_idle);
    drive(0, 'h2B, 'h00, 0); check("sw_rst_ma_rst", 0, e_ma);
    drive(1, 'h2B, 'h00, 0); check("sw_rst_after", 0, e_fetch);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle control unit for the MIPS datapath. A Moore state machine sequences each instruction through fetch, decode, execute, memory and write-back cycles. It drives every write enable and mux select in the datapath, including the register-file write strobe `RFWr`, the destination select for `A3`, and the write-data select for `WD`. It sits directly upstream of the register file and consumes only the instruction-register fields and the ALU `Zero` flag.

## Interface
Parameters:
- `ST_W`, 4: width of the state register.

Ports:
- `clk` input 1: system clock; all state changes occur on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `Op` input 6: IR[31:26].
- `Funct` input 6: IR[5:0].
- `Zero` input 1: ALU zero flag from the EXE cycle.
- `PCWr` output 1: PC write enable.
- `IRWr` output 1: instruction register write enable.
- `RFWr` output 1: register file write enable.
- `DMWr` output 1: data memory write enable.
- `BSel` output 1: ALU B source; 0 = RD2, 1 = extended immediate.
- `ALUOp` output 3: ALU function code.
- `EXTOp` output 2: immediate extender mode; zero-extend, sign-extend, or upper-load.
- `GPRSel` output 2: `A3` source; rd, rt, or 31.
- `WDSel` output 2: `WD` source; ALU result, DM read data, or PC.
- `NPCOp` output 2: next-PC mode; PC+4, branch, or jump.
- `Illegal` output 1: one-cycle pulse in DCD when the opcode or funct is unsupported.

## Operation
- Supported instructions:
  - R-type (`Op`=0): addu (21h), subu (23h), and (24h), or (25h), slt (2Ah).
  - ori (0Dh), lui (0Fh), lw (23h), sw (2Bh), beq (04h), j (02h), jal (03h).
- States: FETCH, DCD, EXE_R, EXE_I, MA, MR, MW, WB_ALU, WB_MEM, BR, JMP.
- FETCH:
  - Asserts `IRWr`=1, `PCWr`=1, `NPCOp`=PC+4.
  - Always transitions to DCD.
- DCD performs no writes and dispatches on the opcode:
  - R-type → EXE_R.
  - ori or lui → EXE_I.
  - lw or sw → MA.
  - beq → BR.
  - j or jal → JMP.
  - Anything else → FETCH, with `Illegal`=1 for that cycle.
- EXE_R drives `BSel`=0 and `ALUOp` from `Funct`, then → WB_ALU.
- EXE_I drives `BSel`=1 and `EXTOp` as zero-extend (ori) or upper-load (lui), then → WB_ALU.
- MA drives `BSel`=1, `EXTOp`=sign-extend, `ALUOp`=ADD:
  - lw → MR.
  - sw → MW.
- MW asserts `DMWr`=1, then → FETCH.
- MR performs no writes (memory read latency), then → WB_MEM.
- WB_ALU asserts `RFWr`=1 and `WDSel`=ALU:
  - `GPRSel`=rd for R-type, rt for I-type.
  - Then → FETCH.
- WB_MEM asserts `RFWr`=1, `WDSel`=DM, `GPRSel`=rt, then → FETCH.
- BR drives `ALUOp`=SUB and `NPCOp`=branch, with `PCWr`=`Zero`, then → FETCH.
- JMP asserts `PCWr`=1 with `NPCOp`=jump:
  - For jal, also asserts `RFWr`=1, `GPRSel`=31, `WDSel`=PC (PC already holds PC+4).
  - Then → FETCH.
- In any state other than those listed above, every write enable is 0.
- Mux selects are don't-care when unused, but are driven to 0 so that waveforms stay deterministic.
- The instruction subset and all encodings are frozen for this revision.

## Timing
- The state register updates on the rising edge of `clk`.
- All outputs are combinational decode of the state register plus `Op`, `Funct` and `Zero`.
- `Op` and `Funct` come from the IR and are stable from DCD until the next FETCH.
- Reset:
  - With `rst`=0 at a rising edge, the state becomes FETCH.
  - While `rst`=0, `PCWr`, `IRWr`, `RFWr`, `DMWr` and `Illegal` are forced to 0.
  - Reset asserted mid-instruction aborts it: no further writes, and fetch restarts on the first edge with `rst`=1.
- Cycles per instruction:
  - R-type, ori, lui, sw: 4.
  - lw: 5.
  - beq, j, jal: 3.
  - Illegal instruction: 2.
- `RFWr` and `DMWr` are each high for exactly one cycle per instruction, or not at all.
- `PCWr` is high in FETCH; in BR it is high only if `Zero`=1; in JMP it is high. `IRWr` is high in FETCH.
- A `Zero` change outside BR has no effect.

## Structure
- Package `mc_pkg` holds:
  - State encodings.
  - Opcode and funct constants.
  - `ALUOp` codes: ADD=0, SUB=1, AND=2, OR=3, SLT=4, LUI=5.
  - `EXTOp`, `GPRSel`, `WDSel` and `NPCOp` encodings.
- A single sub-module, `mc_alu_dec`, maps `Funct` or `Op` to `ALUOp`; the rest of the block is the FSM.

## Test plan
- Reset and R-type:
  - Hold `rst`=0 for 3 cycles → all enables stay 0.
  - Release with `Op`=0, `Funct`=21h → states FETCH, DCD, EXE_R, WB_ALU.
  - `RFWr`=1 only in cycle 4, with `GPRSel`=rd and `ALUOp`=ADD.
- lw (`Op`=23h) → 5 cycles:
  - `WDSel`=DM, `GPRSel`=rt, `RFWr` pulses in cycle 5.
  - `DMWr` stays 0 throughout.
- sw (`Op`=2Bh) → `DMWr`=1 in cycle 4 only; `RFWr` never asserted.
- beq (`Op`=04h):
  - With `Zero`=1 → `PCWr`=1 in cycle 3 with `NPCOp`=branch.
  - Repeat with `Zero`=0 → `PCWr`=0 in cycle 3.
- jal (`Op`=03h) → cycle 3 has `PCWr`=1, `RFWr`=1, `GPRSel`=31, `WDSel`=PC.
- Illegal and mid-instruction reset:
  - `Op`=3Fh → `Illegal`=1 in DCD, next state FETCH, no writes.
  - Assert `rst`=0 during lw's MR → `RFWr` never rises, and the state is FETCH after release.
